// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter
// Shares one external SRAM/bus port between instruction fetch (if_*) and the
// data-memory stage (d_*). Only one transaction is in flight at a time. Each
// completed transaction returns a one-cycle valid pulse to its requester.
// Ties are resolved by alternating between the two requesters.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   if_req/if_addr  fetch request and PC, held until if_valid or flush
//   if_flush        redirect; the outstanding fetch result is dropped
//   if_rdata/if_valid/if_stall   fetch response and pipeline freeze
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request, held until d_valid
//   d_rdata/d_valid/d_stall      data response and pipeline freeze
//   m_req/m_we/m_be/m_addr/m_wdata  registered memory-port request
//   m_rdata/m_ack   memory response; m_ack may arrive after any number of waits
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack
);
  localparam int BE_W = DATA_W/8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e              state_q;
  logic                last_d_q;   // previous grant went to the data side
  logic                kill_q;     // fetch in flight was flushed
  logic                m_req_q, m_we_q;
  logic [BE_W-1:0]     m_be_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                if_valid_q, d_valid_q;

  // Data wins unless fetch is also waiting and data had the last grant.
  logic pick_data;
  assign pick_data = d_req & (~if_req | ~last_d_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_d_q   <= 1'b0;
      kill_q     <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (pick_data) begin
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_be_q    <= d_be;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            last_d_q  <= 1'b1;
            state_q   <= BUSY_D;
          end else if (if_req) begin
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_be_q    <= '1;
            m_addr_q  <= if_addr;
            m_wdata_q <= '0;
            last_d_q  <= 1'b0;
            state_q   <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (if_flush) kill_q <= 1'b1;
          if (m_ack) begin
            m_req_q <= 1'b0;
            // A flush on the ack edge itself must also suppress the result.
            if (!kill_q && !if_flush) begin
              if_rdata_q <= m_rdata;
              if_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        BUSY_D: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            if (!m_we_q) d_rdata_q <= m_rdata;
            d_valid_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          // Requester's req is still high this cycle; do not re-grant it.
          if_valid_q <= 1'b0;
          d_valid_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign d_rdata  = d_rdata_q;
  assign d_valid  = d_valid_q;
  assign if_stall = if_req & ~if_valid_q;
  assign d_stall  = d_req & ~d_valid_q;
endmodule
